sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter N_ACC, default 4, giving the number of sums accumulated per frame (legal range 2..256).
REQ-002 The block SHALL have parameter ACC_W, default 20, giving the signed accumulator and result width (legal range 17..32).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port clr, input, 1 bit: synchronous frame abort.
REQ-006 Port in_valid, input, 1 bit: in_sum carries a sample this cycle.
REQ-007 Port in_sum, input, 17 bits: signed two's-complement 17-bit sum from the upstream 16-bit pipelined adder.
REQ-008 Port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 Port out_valid, output, 1 bit: out_acc and out_ovf hold a completed frame.
REQ-010 Port out_ready, input, 1 bit: the downstream consumer accepts the frame.
REQ-011 Port out_acc, output, ACC_W bits: signed frame total.
REQ-012 Port out_ovf, output, 1 bit: saturation occurred in the frame.

Function
REQ-013 A sample SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-014 The block SHALL implement two states, ACC and HOLD; in_ready SHALL be 1 in ACC and 0 in HOLD, decoded from registered state only.
REQ-015 In ACC, each accepted sample SHALL be sign-extended to ACC_W+1 bits and added to acc, and the sum SHALL be saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-016 If any accepted sample in a frame saturates, a sticky ovf flag SHALL be set for the rest of that frame.
REQ-017 A 0-to-N_ACC-1 sample counter SHALL increment per accepted sample.
REQ-018 The acceptance that makes the count reach N_ACC SHALL do all of the following on the same edge: load the saturated total into out_acc, load the sticky ovf (including this sample's saturation) into out_ovf, set out_valid=1, clear acc, ovf and the counter, and enter HOLD.
REQ-019 Latency SHALL be one cycle: out_valid rises on the edge that accepts the N_ACC-th sample.
REQ-020 In HOLD, out_acc, out_ovf and out_valid SHALL stay stable until out_valid=1 and out_ready=1 on a rising edge; that edge SHALL clear out_valid and return the state to ACC.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 in_valid while in HOLD SHALL be ignored; the upstream holds the sample.
REQ-023 clr=1 in ACC SHALL clear acc, ovf and the counter, and SHALL discard any sample presented that cycle.
REQ-024 clr=1 in HOLD SHALL leave the pending output untouched and SHALL NOT clear out_valid.
REQ-025 clr takes priority over acceptance in the same cycle.
REQ-026 No combinational path SHALL exist from in_valid or in_sum to any output, or from out_ready to in_ready.

Reset
REQ-027 rst_n=0 SHALL immediately and asynchronously force: state=ACC, acc=0, counter=0, ovf=0, out_valid=0, out_acc=0, out_ovf=0.
REQ-028 While rst_n=0, in_ready SHALL be 1 (state ACC).
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending results.
REQ-030 The first sample SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 The bench SHALL cover: defaults, in_sum 100,200,-50,7 accepted back-to-back, out_ready=1 -> out_acc=257 and out_ovf=0 one cycle after the 4th acceptance, then out_valid=0 the next cycle.
REQ-032 The bench SHALL cover: out_ready=0 for 5 cycles after out_valid, with in_valid held high -> in_ready=0 and out_acc stable for all 5 cycles, no sample lost, and the next frame starting on the cycle after the handshake.
REQ-033 The bench SHALL cover: ACC_W=18 with four samples of 65535 -> out_acc=131071 and out_ovf=1.
REQ-034 The bench SHALL cover: ACC_W=18 with four samples of -65536 -> out_acc=-131072 and out_ovf=1; the following frame of 1,1,1,1 -> out_acc=4 and out_ovf=0.
REQ-035 The bench SHALL cover: two samples of 10, then clr=1 together with in_valid on sample 30, then 1,2,3,4 -> out_acc=10.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-frame after samples 5,5 and in HOLD -> outputs zero at once, in_ready=1, next frame 1,1,1,1 -> out_acc=4.

Source files
------------

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the sample source, the frame accumulator and the frame consumer.
interface sum_accumulator_if #(
    parameter int ACC_W = 20
);
    logic             clr;
    logic             in_valid;
    logic [16:0]      in_sum;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    modport master (
        output clr, in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  clr, in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/sum_accumulator.sv
// Saturating frame accumulator: sums N_ACC signed 17-bit samples and holds the total until taken.
//   state | meaning
//   ACC   | accepting samples into acc, in_ready=1
//   HOLD  | frame total pending on out_acc/out_ovf, waiting for out_ready
module sum_accumulator #(
    parameter int N_ACC = 4,
    parameter int ACC_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    sum_accumulator_if.slave   bus
);
    localparam int CNT_W = (N_ACC > 2) ? $clog2(N_ACC) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic              out_ovf_q, out_ovf_d;

    logic [ACC_W:0]    sum_w;
    logic              sat_hi, sat_lo, sat_any;
    logic [ACC_W-1:0]  acc_sat;

    // One guard bit is enough: a 17-bit sample added to an ACC_W>=17 value cannot wrap ACC_W+1 bits.
    always_comb begin
        sum_w   = {{(ACC_W+1-17){bus.in_sum[16]}}, bus.in_sum} + {acc_q[ACC_W-1], acc_q};
        sat_hi  = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
        sat_lo  =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
        sat_any = sat_hi | sat_lo;
        if (sat_hi)
            acc_sat = ACC_MAX;
        else if (sat_lo)
            acc_sat = ACC_MIN;
        else
            acc_sat = sum_w[ACC_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACC: begin
                if (bus.clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (bus.in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        out_acc_d   = acc_sat;
                        out_ovf_d   = ovf_q | sat_any;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = acc_sat;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | sat_any;
                    end
                end
            end
            HOLD: begin
                // clr is deliberately ignored here so a finished frame is never lost.
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default 20-bit instance plus an 18-bit instance for saturation.
module tb_sum_accumulator;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sum_accumulator_if #(.ACC_W(20)) a_if ();
    sum_accumulator_if #(.ACC_W(18)) b_if ();

    sum_accumulator #(.N_ACC(4), .ACC_W(20)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    sum_accumulator #(.N_ACC(4), .ACC_W(18)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int v);
        a_if.in_valid = 1'b1;
        a_if.in_sum   = 17'(v);
        tick();
    endtask

    task automatic push_b(input int v);
        b_if.in_valid = 1'b1;
        b_if.in_sum   = 17'(v);
        tick();
    endtask

    function automatic int acc_a();
        return int'($signed(a_if.out_acc));
    endfunction

    function automatic int acc_b();
        return int'($signed(b_if.out_acc));
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a_if.clr = 1'b0; a_if.in_valid = 1'b0; a_if.in_sum = '0; a_if.out_ready = 1'b1;
        b_if.clr = 1'b0; b_if.in_valid = 1'b0; b_if.in_sum = '0; b_if.out_ready = 1'b1;
        #2;
        chk("rst_in_ready", int'(a_if.in_ready), 1);
        chk("rst_out_valid", int'(a_if.out_valid), 0);
        chk("rst_out_acc", acc_a(), 0);
        chk("rst_out_ovf", int'(a_if.out_ovf), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Basic frame, back-to-back, consumer always ready
        push_a(100);
        push_a(200);
        push_a(-50);
        chk("basic_not_yet", int'(a_if.out_valid), 0);
        push_a(7);
        a_if.in_valid = 1'b0;
        chk("basic_valid", int'(a_if.out_valid), 1);
        chk("basic_acc", acc_a(), 257);
        chk("basic_ovf", int'(a_if.out_ovf), 0);
        chk("basic_hold_ready", int'(a_if.in_ready), 0);
        tick();
        chk("basic_valid_drop", int'(a_if.out_valid), 0);
        chk("basic_ready_back", int'(a_if.in_ready), 1);

        // Backpressure: consumer stalls five cycles while the next sample waits
        a_if.out_ready = 1'b0;
        push_a(1);
        push_a(2);
        push_a(3);
        push_a(4);
        a_if.in_sum = 17'(10);
        chk("bp_valid", int'(a_if.out_valid), 1);
        chk("bp_acc", acc_a(), 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_ready_%0d", i), int'(a_if.in_ready), 0);
            chk($sformatf("bp_acc_%0d", i), acc_a(), 10);
            chk($sformatf("bp_valid_%0d", i), int'(a_if.out_valid), 1);
        end
        a_if.out_ready = 1'b1;
        tick();
        chk("bp_handshake_valid", int'(a_if.out_valid), 0);
        chk("bp_handshake_ready", int'(a_if.in_ready), 1);
        push_a(10);
        push_a(20);
        push_a(30);
        push_a(40);
        a_if.in_valid = 1'b0;
        chk("bp_next_valid", int'(a_if.out_valid), 1);
        chk("bp_next_acc", acc_a(), 100);
        tick();

        // Positive saturation on the 18-bit instance
        push_b(65535);
        push_b(65535);
        push_b(65535);
        push_b(65535);
        b_if.in_valid = 1'b0;
        chk("satp_valid", int'(b_if.out_valid), 1);
        chk("satp_acc", acc_b(), 131071);
        chk("satp_ovf", int'(b_if.out_ovf), 1);
        tick();

        // Negative saturation, then a clean frame clears the sticky flag
        push_b(-65536);
        push_b(-65536);
        push_b(-65536);
        push_b(-65536);
        b_if.in_valid = 1'b0;
        chk("satn_acc", acc_b(), -131072);
        chk("satn_ovf", int'(b_if.out_ovf), 1);
        tick();
        push_b(1);
        push_b(1);
        push_b(1);
        push_b(1);
        b_if.in_valid = 1'b0;
        chk("clean_acc", acc_b(), 4);
        chk("clean_ovf", int'(b_if.out_ovf), 0);
        tick();

        // Frame abort with a simultaneous sample that must be discarded
        push_a(10);
        push_a(10);
        a_if.clr = 1'b1;
        push_a(30);
        a_if.clr = 1'b0;
        push_a(1);
        push_a(2);
        push_a(3);
        chk("clr_no_early", int'(a_if.out_valid), 0);
        push_a(4);
        a_if.in_valid = 1'b0;
        chk("clr_valid", int'(a_if.out_valid), 1);
        chk("clr_acc", acc_a(), 10);
        tick();

        // clr in HOLD must not disturb the pending frame
        a_if.out_ready = 1'b0;
        push_a(7);
        push_a(7);
        push_a(7);
        push_a(7);
        a_if.in_valid = 1'b0;
        a_if.clr = 1'b1;
        tick();
        a_if.clr = 1'b0;
        chk("hold_clr_valid", int'(a_if.out_valid), 1);
        chk("hold_clr_acc", acc_a(), 28);

        // Reset in HOLD: pending result vanishes without a clock edge
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", int'(a_if.out_valid), 0);
        chk("rst_hold_acc", acc_a(), 0);
        chk("rst_hold_ready", int'(a_if.in_ready), 1);
        tick();
        rst_n = 1'b1;
        a_if.out_ready = 1'b1;

        // Reset mid-frame after 5,5 discards the partial sum
        push_a(5);
        push_a(5);
        a_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", int'(a_if.in_ready), 1);
        chk("rst_mid_valid", int'(a_if.out_valid), 0);
        tick();
        rst_n = 1'b1;
        push_a(1);
        push_a(1);
        push_a(1);
        push_a(1);
        a_if.in_valid = 1'b0;
        chk("rst_next_valid", int'(a_if.out_valid), 1);
        chk("rst_next_acc", acc_a(), 4);
        chk("rst_next_ovf", int'(a_if.out_ovf), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
